// File: rtl/carrier_wipeoff_pkg.sv
// rtl/carrier_wipeoff_pkg.sv - sample decode, sin/cos table generation and config field layout
package carrier_wipeoff_pkg;

  // config field offsets are relative to PHASE_W (the increment occupies [PHASE_W-1:0])
  localparam int CFG_CH_OFS  = 0;
  localparam int CFG_CH_W    = 7;
  localparam int CFG_RST_OFS = 7;

  function automatic logic signed [2:0] decode_sample(input logic [1:0] d);
    case (d)
      2'b00:   decode_sample = 3'b001;
      2'b01:   decode_sample = 3'b011;
      2'b10:   decode_sample = 3'b111;
      default: decode_sample = 3'b101;
    endcase
  endfunction

  // elaboration-time table entry: round((2^(amp_w-1)-1) * cos/sin(2*pi*k/2^lut_aw))
  function automatic int trig_entry(input int k, input int lut_aw, input int amp_w,
                                    input bit want_sin);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << lut_aw);
    v = real'((1 << (amp_w - 1)) - 1) * (want_sin ? $sin(ang) : $cos(ang));
    trig_entry = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/carrier_wipeoff_nco_channel.sv
// rtl/carrier_wipeoff_nco_channel.sv - one carrier: phase accumulator, wrap counter, lookup, mix
module nco_channel
  import carrier_wipeoff_pkg::*;
#(
  parameter  int PHASE_W = 32,
  parameter  int LUT_AW  = 6,
  parameter  int AMP_W   = 8,
  localparam int OUT_W   = AMP_W + 2
) (
  input  logic                     i_aclk,
  input  logic                     i_aresetn,
  input  logic                     i_sample_vld,
  input  logic                     i_v1,
  input  logic                     i_v2,
  input  logic signed [2:0]        i_s2,
  input  logic                     i_cfg_we,
  input  logic                     i_cfg_rst,
  input  logic [PHASE_W-1:0]       i_cfg_inc,
  output logic signed [OUT_W-1:0]  o_i,
  output logic signed [OUT_W-1:0]  o_q,
  output logic [15:0]              o_cycles
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [PHASE_W-1:0]       r_acc;
  logic [PHASE_W-1:0]       r_inc;
  logic [15:0]              r_cycles;
  logic [LUT_AW-1:0]        r_k1;
  logic signed [AMP_W-1:0]  r_cos2;
  logic signed [AMP_W-1:0]  r_sin2;
  logic signed [OUT_W-1:0]  r_i;
  logic signed [OUT_W-1:0]  r_q;
  logic [PHASE_W:0]         w_sum;
  logic signed [AMP_W-1:0]  w_cos_tab [DEPTH];
  logic signed [AMP_W-1:0]  w_sin_tab [DEPTH];
  logic signed [OUT_W-1:0]  w_s_ext;
  logic signed [OUT_W-1:0]  w_cos_ext;
  logic signed [OUT_W-1:0]  w_sin_ext;
  logic signed [OUT_W-1:0]  w_prod_i;
  logic signed [OUT_W-1:0]  w_prod_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam int COS_V = trig_entry(g, LUT_AW, AMP_W, 1'b0);
    localparam int SIN_V = trig_entry(g, LUT_AW, AMP_W, 1'b1);
    assign w_cos_tab[g] = AMP_W'(COS_V);
    assign w_sin_tab[g] = AMP_W'(SIN_V);
  end

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_s_ext   = {{(OUT_W-3){i_s2[2]}}, i_s2};
  assign w_cos_ext = {{2{r_cos2[AMP_W-1]}}, r_cos2};
  assign w_sin_ext = {{2{r_sin2[AMP_W-1]}}, r_sin2};
  assign w_prod_i  = w_s_ext * w_cos_ext;
  assign w_prod_q  = w_s_ext * w_sin_ext;

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_acc    <= '0;
      r_inc    <= '0;
      r_cycles <= '0;
      r_k1     <= '0;
      r_cos2   <= '0;
      r_sin2   <= '0;
      r_i      <= '0;
      r_q      <= '0;
    end else begin
      if (i_sample_vld) begin
        r_k1  <= r_acc[PHASE_W-1 -: LUT_AW];
        r_acc <= w_sum[PHASE_W-1:0];
        if (w_sum[PHASE_W]) r_cycles <= r_cycles + 16'd1;
      end
      // the sample above already captured the old phase; a phase reset wins over its accumulate
      if (i_cfg_we) begin
        r_inc <= i_cfg_inc;
        if (i_cfg_rst) begin
          r_acc    <= '0;
          r_cycles <= '0;
        end
      end
      if (i_v1) begin
        r_cos2 <= w_cos_tab[r_k1];
        r_sin2 <= w_sin_tab[r_k1];
      end
      if (i_v2) begin
        r_i <= w_prod_i;
        r_q <= -w_prod_q;
      end
    end
  end

  assign o_i      = r_i;
  assign o_q      = r_q;
  assign o_cycles = r_cycles;

endmodule

// File: rtl/carrier_wipeoff_nco.sv
// rtl/carrier_wipeoff_nco.sv - multi-channel GNSS carrier wipeoff with per-channel NCO
module carrier_wipeoff_nco
  import carrier_wipeoff_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int PHASE_W = 32,
  parameter  int LUT_AW  = 6,
  parameter  int AMP_W   = 8,
  localparam int OUT_W   = AMP_W + 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [1:0]                data_in,
  input  logic                      data_in_valid,
  input  logic [PHASE_W+7:0]        s_axis_config_tdata,
  input  logic                      s_axis_config_tvalid,
  output logic                      s_axis_config_tready,
  output logic [NUM_CH*OUT_W-1:0]   m_i,
  output logic [NUM_CH*OUT_W-1:0]   m_q,
  output logic                      m_valid,
  output logic [NUM_CH*16-1:0]      m_cycles
);

  logic                 w_cfg_fire;
  logic [CFG_CH_W-1:0]  w_cfg_ch;
  logic                 w_cfg_rst;
  logic [PHASE_W-1:0]   w_cfg_inc;
  logic [NUM_CH-1:0]    w_cfg_hit;
  logic signed [2:0]    r_s1;
  logic signed [2:0]    r_s2;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_v3;

  assign s_axis_config_tready = aresetn;
  assign w_cfg_fire = s_axis_config_tvalid & s_axis_config_tready;
  assign w_cfg_inc  = s_axis_config_tdata[PHASE_W-1:0];
  assign w_cfg_ch   = s_axis_config_tdata[PHASE_W+CFG_CH_OFS +: CFG_CH_W];
  assign w_cfg_rst  = s_axis_config_tdata[PHASE_W+CFG_RST_OFS];

  // sample and valid pipeline shared by all channels
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      r_v1 <= data_in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (data_in_valid) r_s1 <= decode_sample(data_in);
      if (r_v1) r_s2 <= r_s1;
    end
  end

  assign m_valid = r_v3;

  // an out-of-range index matches no channel and is dropped
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_cfg_hit[c] = w_cfg_fire && (w_cfg_ch == CFG_CH_W'(c));

    nco_channel #(
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW),
      .AMP_W   (AMP_W)
    ) u_nco_channel (
      .i_aclk       (aclk),
      .i_aresetn    (aresetn),
      .i_sample_vld (data_in_valid),
      .i_v1         (r_v1),
      .i_v2         (r_v2),
      .i_s2         (r_s2),
      .i_cfg_we     (w_cfg_hit[c]),
      .i_cfg_rst    (w_cfg_rst),
      .i_cfg_inc    (w_cfg_inc),
      .o_i          (m_i[c*OUT_W +: OUT_W]),
      .o_q          (m_q[c*OUT_W +: OUT_W]),
      .o_cycles     (m_cycles[c*16 +: 16])
    );
  end

endmodule

// File: tb/tb_carrier_wipeoff_nco.sv
// tb/tb_carrier_wipeoff_nco.sv - self-checking bench for carrier_wipeoff_nco
module tb_carrier_wipeoff_nco;
  localparam int NUM_CH  = 4;
  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 6;
  localparam int AMP_W   = 8;
  localparam int OUT_W   = AMP_W + 2;
  localparam longint unsigned MODV = 64'd1 << PHASE_W;
  localparam logic [31:0] Q_TURN = 32'h4000_0000;

  logic                     aclk = 1'b0;
  logic                     aresetn;
  logic [1:0]               data_in;
  logic                     data_in_valid;
  logic [PHASE_W+7:0]       s_axis_config_tdata;
  logic                     s_axis_config_tvalid;
  logic                     s_axis_config_tready;
  logic [NUM_CH*OUT_W-1:0]  m_i;
  logic [NUM_CH*OUT_W-1:0]  m_q;
  logic                     m_valid;
  logic [NUM_CH*16-1:0]     m_cycles;

  always #5 aclk = ~aclk;

  carrier_wipeoff_nco #(
    .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .data_in              (data_in),
    .data_in_valid        (data_in_valid),
    .s_axis_config_tdata  (s_axis_config_tdata),
    .s_axis_config_tvalid (s_axis_config_tvalid),
    .s_axis_config_tready (s_axis_config_tready),
    .m_i                  (m_i),
    .m_q                  (m_q),
    .m_valid              (m_valid),
    .m_cycles             (m_cycles)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model: ideal trig values, phases as plain integers, 3-deep result delay line
  int              cos_t [1 << LUT_AW];
  int              sin_t [1 << LUT_AW];
  longint unsigned ph    [NUM_CH];
  longint unsigned inc   [NUM_CH];
  int              cyc   [NUM_CH];
  bit              lv    [3];
  int              li    [3][NUM_CH];
  int              lq    [3][NUM_CH];
  bit              ev;
  int              ei    [NUM_CH];
  int              eq    [NUM_CH];

  typedef struct {
    logic [1:0] din;
    logic       vld;
    logic       ev;
    int         i0, q0, i1, q1, cyc1;
  } vec_t;
  vec_t tbl [12];

  function automatic int dut_i(int c);
    return int'($signed(m_i[c*OUT_W +: OUT_W]));
  endfunction
  function automatic int dut_q(int c);
    return int'($signed(m_q[c*OUT_W +: OUT_W]));
  endfunction
  function automatic int dut_cyc(int c);
    return int'(m_cycles[c*16 +: 16]);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int s;
    int k;
    int ch;
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ph[c] = 0; inc[c] = 0; cyc[c] = 0; ei[c] = 0; eq[c] = 0;
      end
      for (int j = 0; j < 3; j++) lv[j] = 1'b0;
      ev = 1'b0;
      return;
    end
    for (int j = 2; j > 0; j--) begin
      lv[j] = lv[j-1];
      for (int c = 0; c < NUM_CH; c++) begin
        li[j][c] = li[j-1][c];
        lq[j][c] = lq[j-1][c];
      end
    end
    s = data_in[0] ? 3 : 1;
    if (data_in[1]) s = -s;
    lv[0] = data_in_valid;
    for (int c = 0; c < NUM_CH; c++) begin
      k = int'(ph[c] >> (PHASE_W - LUT_AW));
      li[0][c] = s * cos_t[k];
      lq[0][c] = -s * sin_t[k];
    end
    ev = lv[2];
    if (ev) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ei[c] = li[2][c];
        eq[c] = lq[2][c];
      end
    end
    if (data_in_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ph[c] = ph[c] + inc[c];
        if (ph[c] >= MODV) begin
          ph[c] = ph[c] - MODV;
          cyc[c] = (cyc[c] + 1) % 65536;
        end
      end
    end
    if (s_axis_config_tvalid) begin
      ch = int'(s_axis_config_tdata[PHASE_W +: 7]);
      if (ch < NUM_CH) begin
        inc[ch] = longint'(s_axis_config_tdata[PHASE_W-1:0]);
        if (s_axis_config_tdata[PHASE_W+7]) begin
          ph[ch] = 0;
          cyc[ch] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge aclk);
    #1;
    chk("model_valid", int'(m_valid), int'(ev));
    chk("tready", int'(s_axis_config_tready), int'(aresetn));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("model_i%0d", c), dut_i(c), ei[c]);
      chk($sformatf("model_q%0d", c), dut_q(c), eq[c]);
      chk($sformatf("model_cyc%0d", c), dut_cyc(c), cyc[c]);
    end
  endtask

  task automatic set_cfg(input bit v, input int ch, input bit rst, input logic [31:0] incv);
    s_axis_config_tvalid = v;
    s_axis_config_tdata  = {rst, 7'(ch), incv};
  endtask

  task automatic sample(input bit v, input logic [1:0] d);
    data_in_valid = v;
    data_in       = d;
  endtask

  initial begin
    for (int k = 0; k < (1 << LUT_AW); k++) begin
      real a;
      real cv;
      real sv;
      a  = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << LUT_AW);
      cv = 127.0 * $cos(a);
      sv = 127.0 * $sin(a);
      cos_t[k] = (cv >= 0.0) ? $rtoi(cv + 0.5) : -$rtoi(0.5 - cv);
      sin_t[k] = (sv >= 0.0) ? $rtoi(sv + 0.5) : -$rtoi(0.5 - sv);
    end

    tbl[0]  = '{2'b01, 1'b1, 1'b0,    0, 0,    0,    0, 0};
    tbl[1]  = '{2'b00, 1'b1, 1'b0,    0, 0,    0,    0, 0};
    tbl[2]  = '{2'b00, 1'b1, 1'b1,  381, 0,  381,    0, 0};
    tbl[3]  = '{2'b00, 1'b1, 1'b1,  127, 0,    0, -127, 1};
    tbl[4]  = '{2'b00, 1'b1, 1'b1,  127, 0, -127,    0, 1};
    tbl[5]  = '{2'b00, 1'b0, 1'b1,  127, 0,    0,  127, 1};
    tbl[6]  = '{2'b00, 1'b0, 1'b1,  127, 0,  127,    0, 1};
    tbl[7]  = '{2'b11, 1'b1, 1'b0,  127, 0,  127,    0, 1};
    tbl[8]  = '{2'b10, 1'b1, 1'b0,  127, 0,  127,    0, 1};
    tbl[9]  = '{2'b00, 1'b0, 1'b1, -381, 0,    0,  381, 1};
    tbl[10] = '{2'b00, 1'b0, 1'b1, -127, 0,  127,    0, 1};
    tbl[11] = '{2'b00, 1'b0, 1'b0, -127, 0,  127,    0, 1};

    aresetn = 1'b0;
    sample(1'b0, 2'b00);
    set_cfg(1'b0, 0, 1'b0, 32'h0);
    tick();
    tick();
    chk("reset_valid", int'(m_valid), 0);
    chk("reset_i0", dut_i(0), 0);
    chk("reset_tready", int'(s_axis_config_tready), 0);

    aresetn = 1'b1;
    set_cfg(1'b1, 1, 1'b0, Q_TURN);
    tick();
    set_cfg(1'b0, 0, 1'b0, 32'h0);

    for (int r = 0; r < 12; r++) begin
      sample(tbl[r].vld, tbl[r].din);
      tick();
      chk($sformatf("tbl%0d_valid", r), int'(m_valid), int'(tbl[r].ev));
      chk($sformatf("tbl%0d_i0", r), dut_i(0), tbl[r].i0);
      chk($sformatf("tbl%0d_q0", r), dut_q(0), tbl[r].q0);
      chk($sformatf("tbl%0d_i1", r), dut_i(1), tbl[r].i1);
      chk($sformatf("tbl%0d_q1", r), dut_q(1), tbl[r].q1);
      chk($sformatf("tbl%0d_cyc1", r), dut_cyc(1), tbl[r].cyc1);
    end

    // phase reset in the same cycle as the sample at P=2^31
    sample(1'b1, 2'b00);
    tick(); tick(); tick();
    set_cfg(1'b1, 1, 1'b1, Q_TURN);
    tick();
    set_cfg(1'b0, 0, 1'b0, 32'h0);
    tick();
    sample(1'b0, 2'b00);
    tick();
    chk("prst_valid", int'(m_valid), 1);
    chk("prst_i1", dut_i(1), -127);
    chk("prst_q1", dut_q(1), 0);
    chk("prst_cyc1", dut_cyc(1), 0);
    tick();
    chk("prst_next_i1", dut_i(1), 127);
    chk("prst_next_q1", dut_q(1), 0);

    // sparse valid pattern 1,0,0,1 from a freshly reset phase
    set_cfg(1'b1, 1, 1'b1, Q_TURN);
    tick();
    set_cfg(1'b0, 0, 1'b0, 32'h0);
    for (int j = 0; j < 7; j++) begin
      sample((j == 0) || (j == 3), 2'b00);
      tick();
      chk($sformatf("sparse%0d_valid", j), int'(m_valid), int'((j == 2) || (j == 5)));
      if (j == 2) begin
        chk("sparse_first_i1", dut_i(1), 127);
        chk("sparse_first_q1", dut_q(1), 0);
      end
      if (j == 5) begin
        chk("sparse_second_i1", dut_i(1), 0);
        chk("sparse_second_q1", dut_q(1), -127);
      end
    end

    // out-of-range channel index must not touch any channel
    set_cfg(1'b1, NUM_CH, 1'b1, 32'h1234_5678);
    tick();
    set_cfg(1'b0, 0, 1'b0, 32'h0);
    sample(1'b1, 2'b00);
    tick();
    sample(1'b0, 2'b00);
    tick(); tick();
    chk("badch_i1", dut_i(1), -127);
    chk("badch_q1", dut_q(1), 0);
    chk("badch_i0", dut_i(0), 127);
    chk("badch_cyc1", dut_cyc(1), 0);

    // one-cycle reset with two samples in flight
    sample(1'b1, 2'b01);
    tick(); tick();
    sample(1'b0, 2'b00);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rst_flight%0d_valid", j), int'(m_valid), 0);
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("rst_flight%0d_i%0d", j, c), dut_i(c), 0);
        chk($sformatf("rst_flight%0d_q%0d", j, c), dut_q(c), 0);
        chk($sformatf("rst_flight%0d_cyc%0d", j, c), dut_cyc(c), 0);
      end
    end

    for (int n = 0; n < 1500; n++) begin
      sample($urandom_range(0, 3) != 0, 2'($urandom));
      if ($urandom_range(0, 3) == 0)
        set_cfg(1'b1, $urandom_range(0, NUM_CH), $urandom_range(0, 7) == 0,
                ($urandom_range(0, 1) == 0) ? 32'($urandom) : Q_TURN);
      else
        set_cfg(1'b0, 0, 1'b0, 32'h0);
      aresetn = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
